// File: rtl/pc_sequencer.sv
// Program-counter / fetch-request sequencer: holds the PC, issues word fetches over req/ack, and redirects on J or register jumps.
// Optional PC_ALIGN_CHECK_EN: forces register targets to word alignment and raises a sticky align_err on misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_pc,
  input  logic [31:0] jmp_offset,
  input  logic        reg_valid,
  input  logic [31:0] reg_target,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        pc_valid_q, pc_valid_d;

  logic        redirect;
  logic [31:0] jmp_target;
  logic [31:0] reg_dest;
  logic [31:0] target;

  assign jmp_target = jmp_pc + (jmp_offset << 2);

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_q;

  assign reg_dest  = {reg_target[31:2], 2'b00};
  assign align_err = align_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_q <= 1'b0;
    end else if (reg_valid && !jmp_valid && (reg_target[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end
`else
  assign reg_dest  = reg_target;
  assign align_err = 1'b0;
`endif

  assign redirect = jmp_valid | reg_valid;
  assign target   = jmp_valid ? jmp_target : reg_dest;
  assign flush    = redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    pc_out_d     = pc_out_q;
    pc_valid_d   = 1'b0;
    fetch_req    = 1'b0;

    if (redirect) begin
      pc_d = target;
    end

    case (state_q)
      IDLE: begin
        if (!stall) begin
          state_d      = FETCH;
          fetch_addr_d = pc_d;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          if (!redirect) begin
            pc_out_d   = fetch_addr_q;
            pc_valid_d = 1'b1;
            pc_d       = fetch_addr_q + 32'd4;
          end
          // pc_d already holds either the sequential successor or the redirect target
          if (stall) begin
            state_d = IDLE;
          end else begin
            fetch_addr_d = pc_d;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          if (stall) begin
            state_d = IDLE;
          end else begin
            state_d      = FETCH;
            fetch_addr_d = pc_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      pc_out_q     <= '0;
      pc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      pc_out_q     <= pc_out_d;
      pc_valid_q   <= pc_valid_d;
    end
  end

  assign fetch_addr = fetch_addr_q;
  assign pc_out     = pc_out_q;
  assign pc_valid   = pc_valid_q;

endmodule
